generador_vecinos: RTL and testbench
====================================

# generador_vecinos

Upstream feeder for `modo_secuencial`: walks the output image in raster order and maps each output pixel to source coordinates in Q8.8. It fetches the four neighbouring source pixels from a synchronous byte memory, one read per cycle. It then presents the four pixels plus `fx`/`fy` to the interpolator through the `iniciar`/`listo` handshake. One `arrancar` pulse processes a full frame; a `hecho` pulse ends it.

## Interface
Parameters:
- `ANCHO_ENT`, 64: source width in pixels (2..256).
- `ALTO_ENT`, 64: source height in pixels (2..256).
- `ANCHO_SAL`, 32: output width in pixels (1..256).
- `ALTO_SAL`, 32: output height in pixels (1..256).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `arrancar`  in  1  start-of-frame pulse; ignored while `ocupado`=1.
- `escala_x`  in  q8_8_t  source/output step in x; sampled on `arrancar`.
- `escala_y`  in  q8_8_t  source/output step in y; sampled on `arrancar`.
- `ocupado`  out  1  high from the cycle after an accepted `arrancar` until `hecho`.
- `hecho`  out  1  one-cycle pulse after the last `iniciar` of the frame.
- `mem_leer`  out  1  read strobe.
- `mem_dir`  out  16  read address, y*ANCHO_ENT + x.
- `mem_dato`  in  8  read data, valid exactly one cycle after `mem_leer`.
- `iniciar`  out  1  one-cycle pulse to the interpolator.
- `listo`  in  1  interpolator can accept a new pixel.
- `p00_salida`, `p10_salida`, `p01_salida`, `p11_salida`  out  8  neighbour pixels.
- `fx_salida`, `fy_salida`  out  q8_8_t  fractional weights, integer byte always 0.
- `coord_x`, `coord_y`  out  8  output-pixel index currently presented.

## Operation
- **Reset values.** All outputs reset to 0. The FSM resets to REPOSO. The accumulators and counters reset to 0.
- **Accumulators.** `acc_x` and `acc_y` are 24-bit Q16.8.
  - `acc_x` clears at the start of each row.
  - `acc_x` adds `escala_x` after each delivered pixel.
  - `acc_y` adds `escala_y` after each row.
- **Coordinate mapping, x axis** (y is identical using `acc_y`, `ALTO_ENT` and `fy`).
  - Let `xi` = `acc_x[23:8]`.
  - If `xi` ≥ ANCHO_ENT-1: x0 = x1 = ANCHO_ENT-1 and fx = 0.
  - Otherwise: x0 = xi, x1 = xi+1, fx = {8'h00, `acc_x[7:0]`}.
- **Neighbour order.** p00=(x0,y0), p10=(x1,y0), p01=(x0,y1), p11=(x1,y1).
- **FSM states:**
  - REPOSO: wait. On `arrancar`, latch the scales, clear the counters and accumulators, go to CALC.
  - CALC: register x0, x1, y0, y1, fx, fy. Go to LEE0.
  - LEE0..LEE3: assert `mem_leer` with the address of p00, p10, p01, p11 respectively.
    - The data for read k is captured in the following state.
    - LEE3 goes to CAP.
  - CAP: capture p11. Go to ENTREGA.
  - ENTREGA: hold all pixel, weight and coordinate outputs stable.
    - If `listo`=1: pulse `iniciar`, advance the counters and accumulators, then go to CALC, or to FIN after the last pixel.
    - If `listo`=0: stay.
  - FIN: pulse `hecho`, clear `ocupado`, go to REPOSO.
- **Raster order.** `coord_x` is the inner loop and `coord_y` the outer loop. The last pixel is (ANCHO_SAL-1, ALTO_SAL-1).
- **Ignored `arrancar`.** An `arrancar` while not in REPOSO has no effect.
- **Reset mid-frame.** The FSM returns to REPOSO immediately. No `iniciar` or `hecho` is emitted.
- **Memory strobe.** `mem_leer` is never asserted outside LEE0..LEE3.

## Timing
- **Start.** `arrancar` sampled at edge 0. CALC occupies cycle 1 and LEE0 cycle 2. The first `iniciar` comes no earlier than cycle 7.
- **Throughput.** 7 cycles per pixel minimum (CALC + 4 reads + CAP + ENTREGA) when `listo` stays high.
- **Data stability.** Pixel and weight outputs change only in CALC/CAP. They are stable for the whole of ENTREGA, including the `iniciar` cycle.
- **Output coordinates.** `coord_x`/`coord_y` update in the cycle after `iniciar`.
- **Back-pressure.** `listo` low for N cycles extends ENTREGA by N cycles. No reads are issued during the stall.
- **End of frame.** `hecho` is asserted in the cycle after the final `iniciar`. `ocupado` falls in the same cycle as `hecho`.

## Test plan
- **Integer scale.** ANCHO_ENT=ALTO_ENT=4, ANCHO_SAL=ALTO_SAL=2, scales 0x0200, memory[a]=a.
  - Pixel (0,0): reads 0,1,4,5; p00..p11 = 0,1,4,5; fx=fy=0.
  - Pixel (1,1): reads 10,11,14,15.
  - Exactly 4 `iniciar` pulses, then `hecho`.
- **Fractional scale.** `escala_x`=0x0180, ANCHO_SAL=2. Pixel (1,0): x0=1, x1=2, fx=0x0080; reads 1,2,5,6.
- **Right-edge clamp.** ANCHO_SAL=3 with `escala_x`=0x0200, ANCHO_ENT=4. Pixel (2,0): xi=4 gives x0=x1=3, fx=0; reads 3,3,7,7. The same check applies on the y axis using `escala_y`.
- **Back-pressure.** Hold `listo`=0 for 5 cycles in ENTREGA.
  - No `iniciar` and no `mem_leer` during the stall; outputs unchanged.
  - `iniciar` fires in the first cycle `listo`=1.
- **Reset and spurious start.**
  - Assert `arrancar` mid-frame: no restart, pixel count unchanged.
  - Drop `rst_n` during LEE2: all outputs are 0 next cycle.
  - A new `arrancar` after reset restarts at pixel (0,0).

Source files
------------

// File: rtl/generador_vecinos_if.sv
// Memory read port and interpolator handshake of the neighbour generator.
// The master side is the generator; the slave side is memory plus interpolator.
interface generador_vecinos_if;
  logic        mem_leer;
  logic [15:0] mem_dir;
  logic [7:0]  mem_dato;
  logic        iniciar;
  logic        listo;
  logic [7:0]  p00_salida;
  logic [7:0]  p10_salida;
  logic [7:0]  p01_salida;
  logic [7:0]  p11_salida;
  logic [15:0] fx_salida;
  logic [15:0] fy_salida;
  logic [7:0]  coord_x;
  logic [7:0]  coord_y;

  modport master (
    output mem_leer, mem_dir, iniciar,
    output p00_salida, p10_salida, p01_salida, p11_salida,
    output fx_salida, fy_salida, coord_x, coord_y,
    input  mem_dato, listo
  );

  modport slave (
    input  mem_leer, mem_dir, iniciar,
    input  p00_salida, p10_salida, p01_salida, p11_salida,
    input  fx_salida, fy_salida, coord_x, coord_y,
    output mem_dato, listo
  );
endinterface

// File: rtl/generador_vecinos.sv
// Raster walker over the output image: maps each pixel to Q8.8 source coords,
// fetches its four neighbours one read per cycle and hands them to the interpolator.
module generador_vecinos #(
  parameter int unsigned ANCHO_ENT = 64,
  parameter int unsigned ALTO_ENT  = 64,
  parameter int unsigned ANCHO_SAL = 32,
  parameter int unsigned ALTO_SAL  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arrancar,
  input  logic [15:0]          escala_x,
  input  logic [15:0]          escala_y,
  output logic                 ocupado,
  output logic                 hecho,
  generador_vecinos_if.master  bus
);

  localparam int unsigned QW   = 16;
  localparam int unsigned ACCW = 24;
  localparam int unsigned CW   = 8;
  localparam int unsigned DW   = 16;

  localparam logic [QW-1:0] XI_LIM = QW'(ANCHO_ENT - 1);
  localparam logic [QW-1:0] YI_LIM = QW'(ALTO_ENT - 1);
  localparam logic [CW-1:0] X_MAX  = CW'(ANCHO_ENT - 1);
  localparam logic [CW-1:0] Y_MAX  = CW'(ALTO_ENT - 1);
  localparam logic [CW-1:0] CX_ULT = CW'(ANCHO_SAL - 1);
  localparam logic [CW-1:0] CY_ULT = CW'(ALTO_SAL - 1);

  typedef enum logic [3:0] {
    REPOSO, CALC, LEE0, LEE1, LEE2, LEE3, CAP, ENTREGA, FIN
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [QW-1:0]    esc_x_q, esc_x_d, esc_y_q, esc_y_d;
  logic [ACCW-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [CW-1:0]    cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
  logic [CW-1:0]    x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [7:0]       frac_x_q, frac_x_d, frac_y_q, frac_y_d;
  logic [7:0]       buf00_q, buf00_d, buf10_q, buf10_d, buf01_q, buf01_d;
  logic [7:0]       p00_q, p00_d, p10_q, p10_d, p01_q, p01_d, p11_q, p11_d;
  logic [7:0]       fx_q, fx_d, fy_q, fy_d;
  logic             leer_q, leer_d;
  logic [DW-1:0]    dir_q, dir_d;
  logic             ocupado_q, ocupado_d;
  logic             hecho_q, hecho_d;

  logic [CW-1:0]    mx0, mx1, my0, my1;
  logic [7:0]       mfx, mfy;

  function automatic logic [DW-1:0] dir_de(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return DW'(y) * DW'(ANCHO_ENT) + DW'(x);
  endfunction

  // Source-coordinate mapping with clamping at the right/bottom edge.
  always_comb begin
    mx0 = X_MAX;
    mx1 = X_MAX;
    mfx = 8'h00;
    my0 = Y_MAX;
    my1 = Y_MAX;
    mfy = 8'h00;
    if (acc_x_q[ACCW-1:8] < XI_LIM) begin
      mx0 = acc_x_q[15:8];
      mx1 = acc_x_q[15:8] + 8'd1;
      mfx = acc_x_q[7:0];
    end
    if (acc_y_q[ACCW-1:8] < YI_LIM) begin
      my0 = acc_y_q[15:8];
      my1 = acc_y_q[15:8] + 8'd1;
      mfy = acc_y_q[7:0];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    estado_d  = estado_q;
    esc_x_d   = esc_x_q;
    esc_y_d   = esc_y_q;
    acc_x_d   = acc_x_q;
    acc_y_d   = acc_y_q;
    cnt_x_d   = cnt_x_q;
    cnt_y_d   = cnt_y_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    frac_x_d  = frac_x_q;
    frac_y_d  = frac_y_q;
    buf00_d   = buf00_q;
    buf10_d   = buf10_q;
    buf01_d   = buf01_q;
    p00_d     = p00_q;
    p10_d     = p10_q;
    p01_d     = p01_q;
    p11_d     = p11_q;
    fx_d      = fx_q;
    fy_d      = fy_q;
    leer_d    = 1'b0;
    dir_d     = '0;
    ocupado_d = 1'b0;
    hecho_d   = 1'b0;

    unique case (estado_q)
      REPOSO: begin
        if (arrancar) begin
          esc_x_d  = escala_x;
          esc_y_d  = escala_y;
          acc_x_d  = '0;
          acc_y_d  = '0;
          cnt_x_d  = '0;
          cnt_y_d  = '0;
          estado_d = CALC;
        end
      end
      CALC: begin
        x0_d     = mx0;
        x1_d     = mx1;
        y0_d     = my0;
        y1_d     = my1;
        frac_x_d = mfx;
        frac_y_d = mfy;
        estado_d = LEE0;
      end
      LEE0: estado_d = LEE1;
      LEE1: begin
        buf00_d  = bus.mem_dato;
        estado_d = LEE2;
      end
      LEE2: begin
        buf10_d  = bus.mem_dato;
        estado_d = LEE3;
      end
      LEE3: begin
        buf01_d  = bus.mem_dato;
        estado_d = CAP;
      end
      CAP: begin
        // All presented values swap together so ENTREGA sees a coherent set.
        p00_d    = buf00_q;
        p10_d    = buf10_q;
        p01_d    = buf01_q;
        p11_d    = bus.mem_dato;
        fx_d     = frac_x_q;
        fy_d     = frac_y_q;
        estado_d = ENTREGA;
      end
      ENTREGA: begin
        if (bus.listo) begin
          if (cnt_x_q == CX_ULT) begin
            if (cnt_y_q == CY_ULT) begin
              estado_d = FIN;
            end else begin
              cnt_x_d  = '0;
              acc_x_d  = '0;
              cnt_y_d  = cnt_y_q + 8'd1;
              acc_y_d  = acc_y_q + ACCW'(esc_y_q);
              estado_d = CALC;
            end
          end else begin
            cnt_x_d  = cnt_x_q + 8'd1;
            acc_x_d  = acc_x_q + ACCW'(esc_x_q);
            estado_d = CALC;
          end
        end
      end
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase

    // Read strobe and address are registered, so they follow the state being entered.
    unique case (estado_d)
      LEE0: begin
        leer_d = 1'b1;
        dir_d  = dir_de(mx0, my0);
      end
      LEE1: begin
        leer_d = 1'b1;
        dir_d  = dir_de(x1_q, y0_q);
      end
      LEE2: begin
        leer_d = 1'b1;
        dir_d  = dir_de(x0_q, y1_q);
      end
      LEE3: begin
        leer_d = 1'b1;
        dir_d  = dir_de(x1_q, y1_q);
      end
      default: ;
    endcase

    ocupado_d = (estado_d != REPOSO) && (estado_d != FIN);
    hecho_d   = (estado_d == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= REPOSO;
      esc_x_q   <= '0;
      esc_y_q   <= '0;
      acc_x_q   <= '0;
      acc_y_q   <= '0;
      cnt_x_q   <= '0;
      cnt_y_q   <= '0;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      frac_x_q  <= '0;
      frac_y_q  <= '0;
      buf00_q   <= '0;
      buf10_q   <= '0;
      buf01_q   <= '0;
      p00_q     <= '0;
      p10_q     <= '0;
      p01_q     <= '0;
      p11_q     <= '0;
      fx_q      <= '0;
      fy_q      <= '0;
      leer_q    <= 1'b0;
      dir_q     <= '0;
      ocupado_q <= 1'b0;
      hecho_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      esc_x_q   <= esc_x_d;
      esc_y_q   <= esc_y_d;
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      cnt_x_q   <= cnt_x_d;
      cnt_y_q   <= cnt_y_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      y0_q      <= y0_d;
      y1_q      <= y1_d;
      frac_x_q  <= frac_x_d;
      frac_y_q  <= frac_y_d;
      buf00_q   <= buf00_d;
      buf10_q   <= buf10_d;
      buf01_q   <= buf01_d;
      p00_q     <= p00_d;
      p10_q     <= p10_d;
      p01_q     <= p01_d;
      p11_q     <= p11_d;
      fx_q      <= fx_d;
      fy_q      <= fy_d;
      leer_q    <= leer_d;
      dir_q     <= dir_d;
      ocupado_q <= ocupado_d;
      hecho_q   <= hecho_d;
    end
  end

  // iniciar must fire in the same cycle listo is seen high, so it stays combinational.
  assign bus.iniciar    = (estado_q == ENTREGA) && bus.listo;
  assign bus.mem_leer   = leer_q;
  assign bus.mem_dir    = dir_q;
  assign bus.p00_salida = p00_q;
  assign bus.p10_salida = p10_q;
  assign bus.p01_salida = p01_q;
  assign bus.p11_salida = p11_q;
  assign bus.fx_salida  = {8'h00, fx_q};
  assign bus.fy_salida  = {8'h00, fy_q};
  assign bus.coord_x    = cnt_x_q;
  assign bus.coord_y    = cnt_y_q;
  assign ocupado        = ocupado_q;
  assign hecho          = hecho_q;

endmodule

// File: tb/tb_generador_vecinos.sv
// Directed bench: 4x4 source of bytes mem[a]=a scaled to a 3x3 output, with
// integer, fractional, clamped, stalled, spurious-start and mid-frame-reset cases.
module tb_generador_vecinos;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arrancar;
  logic [15:0] escala_x;
  logic [15:0] escala_y;
  logic        ocupado;
  logic        hecho;

  generador_vecinos_if bus ();

  generador_vecinos #(
    .ANCHO_ENT(4), .ALTO_ENT(4), .ANCHO_SAL(3), .ALTO_SAL(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arrancar(arrancar),
    .escala_x(escala_x), .escala_y(escala_y),
    .ocupado(ocupado), .hecho(hecho), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) if (bus.mem_leer) bus.mem_dato <= mem[bus.mem_dir[7:0]];

  typedef struct {
    int cx, cy, p00, p10, p01, p11, fx, fy;
  } pix_t;

  pix_t tab [2][9];
  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   spur_cyc;
  int   reads [$];
  int   c_cx, c_cy, c_p00, c_p10, c_p01, c_p11, c_fx, c_fy;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Runs cycles until one iniciar; optionally stalls listo 5 cycles in ENTREGA.
  task automatic wait_pixel(input bit stall, output bit ok, output int icyc);
    int n = 0;
    int scnt = 0;
    logic [31:0] snap_p = '0;
    logic [31:0] snap_f = '0;
    ok = 1'b0;
    icyc = 0;
    reads.delete();
    while (!ok && n < 100) begin
      @(negedge clk);
      cyc++;
      n++;
      arrancar = (cyc == spur_cyc);
      if (cyc == spur_cyc) begin
        escala_x = 16'h0100;
        escala_y = 16'h0100;
      end
      if (scnt > 0) scnt++;
      bus.listo = !(scnt >= 2 && scnt <= 7);
      #1;
      if (cyc == 1) chk("ocupado_start", int'(ocupado), 1);
      if (bus.mem_leer) reads.push_back(int'(bus.mem_dir));
      if (stall && scnt == 0 && reads.size() == 4) scnt = 1;
      if (scnt == 3) begin
        snap_p = {bus.p00_salida, bus.p10_salida, bus.p01_salida, bus.p11_salida};
        snap_f = {bus.fx_salida, bus.fy_salida};
      end
      if (scnt >= 3 && scnt <= 7) begin
        chk("stall_iniciar", int'(bus.iniciar), 0);
        chk("stall_leer", int'(bus.mem_leer), 0);
      end
      if (scnt >= 4 && scnt <= 7) begin
        chk("stall_hold_pix", int'({bus.p00_salida, bus.p10_salida, bus.p01_salida, bus.p11_salida}), int'(snap_p));
        chk("stall_hold_w", int'({bus.fx_salida, bus.fy_salida}), int'(snap_f));
      end
      if (scnt == 8) chk("iniciar_after_stall", int'(bus.iniciar), 1);
      if (bus.iniciar) begin
        ok    = 1'b1;
        icyc  = cyc;
        c_cx  = int'(bus.coord_x);
        c_cy  = int'(bus.coord_y);
        c_p00 = int'(bus.p00_salida);
        c_p10 = int'(bus.p10_salida);
        c_p01 = int'(bus.p01_salida);
        c_p11 = int'(bus.p11_salida);
        c_fx  = int'(bus.fx_salida);
        c_fy  = int'(bus.fy_salida);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_iniciar: got no pulse in 100 cycles expected one");
    end
  endtask

  task automatic run_frame(input int fr, input logic [15:0] sx, input logic [15:0] sy,
                           input int stall_k, input int spur);
    bit ok;
    int icyc;
    pix_t e;
    string pf;
    @(negedge clk);
    escala_x  = sx;
    escala_y  = sy;
    arrancar  = 1'b1;
    bus.listo = 1'b1;
    cyc       = 0;
    spur_cyc  = spur;
    for (int k = 0; k < 9; k++) begin
      wait_pixel(k == stall_k, ok, icyc);
      if (!ok) break;
      e  = tab[fr][k];
      pf = $sformatf("f%0d_px%0d", fr, k);
      chk({pf, "_cx"},  c_cx,  e.cx);
      chk({pf, "_cy"},  c_cy,  e.cy);
      chk({pf, "_p00"}, c_p00, e.p00);
      chk({pf, "_p10"}, c_p10, e.p10);
      chk({pf, "_p01"}, c_p01, e.p01);
      chk({pf, "_p11"}, c_p11, e.p11);
      chk({pf, "_fx"},  c_fx,  e.fx);
      chk({pf, "_fy"},  c_fy,  e.fy);
      chk({pf, "_nreads"}, reads.size(), 4);
      if (reads.size() == 4) begin
        chk({pf, "_rd0"}, reads[0], e.p00);
        chk({pf, "_rd1"}, reads[1], e.p10);
        chk({pf, "_rd2"}, reads[2], e.p01);
        chk({pf, "_rd3"}, reads[3], e.p11);
      end
      if (stall_k < 0 && k < 2) chk({pf, "_latency"}, icyc, 7 * (k + 1));
    end
    @(negedge clk);
    arrancar = 1'b0;
    #1;
    chk("hecho_pulse", int'(hecho), 1);
    chk("ocupado_fin", int'(ocupado), 0);
    chk("iniciar_fin", int'(bus.iniciar), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("hecho_once", int'(hecho), 0);
      chk("no_extra_iniciar", int'(bus.iniciar), 0);
      chk("idle_leer", int'(bus.mem_leer), 0);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ocupado"}, int'(ocupado), 0);
    chk({nm, "_hecho"},   int'(hecho), 0);
    chk({nm, "_leer"},    int'(bus.mem_leer), 0);
    chk({nm, "_dir"},     int'(bus.mem_dir), 0);
    chk({nm, "_iniciar"}, int'(bus.iniciar), 0);
    chk({nm, "_pix"},     int'({bus.p00_salida, bus.p10_salida, bus.p01_salida, bus.p11_salida}), 0);
    chk({nm, "_w"},       int'({bus.fx_salida, bus.fy_salida}), 0);
    chk({nm, "_coord"},   int'({bus.coord_x, bus.coord_y}), 0);
  endtask

  initial begin
    // Frame 0: scales 2.0/2.0; third column and row clamp to source index 3.
    tab[0][0] = '{0, 0,  0,  1,  4,  5, 0, 0};
    tab[0][1] = '{1, 0,  2,  3,  6,  7, 0, 0};
    tab[0][2] = '{2, 0,  3,  3,  7,  7, 0, 0};
    tab[0][3] = '{0, 1,  8,  9, 12, 13, 0, 0};
    tab[0][4] = '{1, 1, 10, 11, 14, 15, 0, 0};
    tab[0][5] = '{2, 1, 11, 11, 15, 15, 0, 0};
    tab[0][6] = '{0, 2, 12, 13, 12, 13, 0, 0};
    tab[0][7] = '{1, 2, 14, 15, 14, 15, 0, 0};
    tab[0][8] = '{2, 2, 15, 15, 15, 15, 0, 0};
    // Frame 1: escala_x 1.5, escala_y 0.5.
    tab[1][0] = '{0, 0, 0, 1, 4,  5,   0,   0};
    tab[1][1] = '{1, 0, 1, 2, 5,  6, 128,   0};
    tab[1][2] = '{2, 0, 3, 3, 7,  7,   0,   0};
    tab[1][3] = '{0, 1, 0, 1, 4,  5,   0, 128};
    tab[1][4] = '{1, 1, 1, 2, 5,  6, 128, 128};
    tab[1][5] = '{2, 1, 3, 3, 7,  7,   0, 128};
    tab[1][6] = '{0, 2, 4, 5, 8,  9,   0,   0};
    tab[1][7] = '{1, 2, 5, 6, 9, 10, 128,   0};
    tab[1][8] = '{2, 2, 7, 7, 11, 11,  0,   0};

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    rst_n     = 1'b0;
    arrancar  = 1'b0;
    escala_x  = '0;
    escala_y  = '0;
    bus.listo = 1'b0;
    spur_cyc  = -1;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    run_frame(0, 16'h0200, 16'h0200, -1, 20);
    run_frame(1, 16'h0180, 16'h0080, 4, -1);

    // Reset dropped while LEE2 is presenting the third read address.
    @(negedge clk);
    escala_x = 16'h0200;
    escala_y = 16'h0200;
    arrancar = 1'b1;
    bus.listo = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      arrancar = 1'b0;
    end
    #1;
    chk("lee2_leer", int'(bus.mem_leer), 1);
    chk("lee2_dir", int'(bus.mem_dir), 4);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    #1;
    chk_all_zero("rst_hold");
    rst_n = 1'b1;

    run_frame(0, 16'h0200, 16'h0200, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
